// File: rtl/sys_ctrl_pkg.sv
// System control package: power sequencer state encoding, divider config
// struct, default timing constants and the counter width helper.
package sys_ctrl_pkg;

    typedef enum logic [2:0] {
        PS_OFF       = 3'd0,
        PS_PLL_CFG   = 3'd1,
        PS_LOCK_WAIT = 3'd2,
        PS_SETTLE    = 3'd3,
        PS_CLK_ON    = 3'd4,
        PS_RUN       = 3'd5,
        PS_STOP_RST  = 3'd6,
        PS_ERROR     = 3'd7
    } pwr_seq_state_e;

    typedef struct packed {
        logic [3:0]  ref_div;
        logic [11:0] fb_div;
    } pll_div_cfg_t;

    localparam int unsigned PWR_SEQ_LOCK_TIMEOUT_DEF = 4096;
    localparam int unsigned PWR_SEQ_SETTLE_DEF       = 16;
    localparam int unsigned PWR_SEQ_RST_HOLD_DEF     = 8;

    // Counter width: clog2 of the largest terminal value, never below 1 bit.
    function automatic int unsigned pwr_seq_cnt_w(input int unsigned a,
                                                  input int unsigned b,
                                                  input int unsigned c);
        int unsigned m;
        int unsigned w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pwr_seq_timer.sv
// Shared sequencer timer: loadable, clearable, saturating up-counter with a
// terminal-count compare against a per-state limit.
module pwr_seq_timer #(
    parameter int unsigned CW = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          inc_i,
    input  logic [CW-1:0] tc_i,
    output logic [CW-1:0] cnt_o,
    output logic          tc_hit_o
);

    // Clear beats load beats increment; increment holds at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                      cnt_o <= '0;
        else if (clr_i)                   cnt_o <= '0;
        else if (load_i)                  cnt_o <= load_val_i;
        else if (inc_i && (cnt_o != '1))  cnt_o <= cnt_o + 1'b1;
    end

    assign tc_hit_o = (cnt_o == tc_i);

endmodule

// File: rtl/core_pwr_seq.sv
// Power-up / power-down sequencer for one core or link clock domain.
// Optional feature: define CORE_PWR_SEQ_TIMEOUT_EN to enable the PLL lock
// timeout in LOCK_WAIT; otherwise LOCK_WAIT waits for lock indefinitely.
module core_pwr_seq
    import sys_ctrl_pkg::*;
#(
    parameter int unsigned LOCK_TIMEOUT    = PWR_SEQ_LOCK_TIMEOUT_DEF,
    parameter int unsigned SETTLE_CYCLES   = PWR_SEQ_SETTLE_DEF,
    parameter int unsigned RST_HOLD_CYCLES = PWR_SEQ_RST_HOLD_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic [3:0]  ref_div_i,
    input  logic [11:0] fb_div_i,
    input  logic        pll_locked_i,
    output logic [3:0]  pll_ref_div_o,
    output logic [11:0] pll_fb_div_o,
    output logic        pll_cfg_valid_o,
    output logic        core_clk_en_o,
    output logic        core_rst_no,
    output logic        busy_o,
    output logic        running_o,
    output logic        err_o,
    output logic [2:0]  state_o
);

`ifdef CORE_PWR_SEQ_TIMEOUT_EN
    localparam int unsigned CW = pwr_seq_cnt_w(LOCK_TIMEOUT, SETTLE_CYCLES, RST_HOLD_CYCLES);
    // Fires as the count reaches LOCK_TIMEOUT-1 unlocked cycles.
    localparam logic [CW-1:0] TC_LOCK = CW'(LOCK_TIMEOUT - 2);
`else
    localparam int unsigned CW = pwr_seq_cnt_w(SETTLE_CYCLES, RST_HOLD_CYCLES, 1);
`endif
    localparam logic [CW-1:0] TC_SETTLE = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] TC_HOLD   = CW'(RST_HOLD_CYCLES - 1);

    if (LOCK_TIMEOUT < 2 || SETTLE_CYCLES < 1 || RST_HOLD_CYCLES < 1) begin : g_param_chk
        $error("core_pwr_seq: timing parameter below its minimum");
    end

    pwr_seq_state_e state_q, state_d;
    pll_div_cfg_t   div_q;
    logic           latch_div;
    logic           tmr_inc, tmr_clr, tmr_hit;
    logic [CW-1:0]  tmr_tc, tmr_cnt;

    pwr_seq_timer #(.CW(CW)) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (tmr_clr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .inc_i      (tmr_inc),
        .tc_i       (tmr_tc),
        .cnt_o      (tmr_cnt),
        .tc_hit_o   (tmr_hit)
    );

    // Next-state and timer control; stop always outranks start.
    always_comb begin
        state_d   = state_q;
        tmr_tc    = TC_HOLD;
        tmr_inc   = 1'b0;
        latch_div = 1'b0;
        case (state_q)
            PS_OFF: begin
                if (start_i && !stop_i) begin
                    latch_div = 1'b1;
                    state_d   = (ref_div_i == '0 || fb_div_i == '0) ? PS_ERROR : PS_PLL_CFG;
                end
            end
            PS_PLL_CFG:   state_d = stop_i ? PS_OFF : PS_LOCK_WAIT;
            PS_LOCK_WAIT: begin
                if (stop_i)            state_d = PS_OFF;
                else if (pll_locked_i) state_d = PS_SETTLE;
`ifdef CORE_PWR_SEQ_TIMEOUT_EN
                else begin
                    tmr_tc  = TC_LOCK;
                    tmr_inc = 1'b1;
                    if (tmr_hit) state_d = PS_ERROR;
                end
`endif
            end
            PS_SETTLE: begin
                tmr_tc = TC_SETTLE;
                if (stop_i)             state_d = PS_OFF;
                else if (!pll_locked_i) state_d = PS_LOCK_WAIT;
                else if (tmr_hit)       state_d = PS_CLK_ON;
                else                    tmr_inc = 1'b1;
            end
            PS_CLK_ON: begin
                if (stop_i)       state_d = PS_STOP_RST;
                else if (tmr_hit) state_d = PS_RUN;
                else              tmr_inc = 1'b1;
            end
            PS_RUN: begin
                if (stop_i)             state_d = PS_STOP_RST;
                else if (!pll_locked_i) state_d = PS_ERROR;
            end
            PS_STOP_RST: begin
                if (tmr_hit) state_d = PS_OFF;
                else         tmr_inc = 1'b1;
            end
            PS_ERROR: if (stop_i) state_d = PS_OFF;
            default:  state_d = PS_OFF;
        endcase
    end

    // Every state change restarts the timer from zero.
    assign tmr_clr = (state_d != state_q);

    // State and domain controls are flopped from the next state so the
    // clock gate and reset lines change cleanly on one edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= PS_OFF;
            core_clk_en_o   <= 1'b0;
            core_rst_no     <= 1'b0;
            pll_cfg_valid_o <= 1'b0;
        end else begin
            state_q         <= state_d;
            core_clk_en_o   <= state_d inside {PS_CLK_ON, PS_RUN, PS_STOP_RST};
            core_rst_no     <= (state_d == PS_RUN);
            pll_cfg_valid_o <= (state_d == PS_PLL_CFG);
        end
    end

    // Dividers are captured on an accepted start and held until the next one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)        div_q <= '0;
        else if (latch_div) div_q <= '{ref_div: ref_div_i, fb_div: fb_div_i};
    end

    assign pll_ref_div_o = div_q.ref_div;
    assign pll_fb_div_o  = div_q.fb_div;
    assign busy_o        = state_q inside {PS_PLL_CFG, PS_LOCK_WAIT, PS_SETTLE, PS_CLK_ON, PS_STOP_RST};
    assign running_o     = (state_q == PS_RUN);
    assign err_o         = (state_q == PS_ERROR);
    assign state_o       = state_q;

endmodule

// File: doc/core_pwr_seq.md
# core_pwr_seq

Power-up/power-down sequencer for one core or link clock domain inside the system control block. On a start request it programs the domain PLL dividers, waits for PLL lock, holds a settle interval, enables the domain clock, and releases the domain reset. On a stop request it asserts reset, then gates the clock. One instance serves each of the E-core, P-core and system-link domains; its outputs drive the domain clock gate and reset lines that the clock/reset control registers otherwise expose.

## Interface
Parameters:
- LOCK_TIMEOUT, 4096: cycles allowed in LOCK_WAIT before error (min 2).
- SETTLE_CYCLES, 16: cycles of stable lock required before clock enable (min 1).
- RST_HOLD_CYCLES, 8: cycles reset stays asserted with the clock running, on both power-up and power-down (min 1).

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous, active-low reset.
- start_i  in  1  single-cycle power-up request.
- stop_i  in  1  single-cycle power-down or error-clear request.
- ref_div_i  in  4  reference divider, sampled when start_i is accepted.
- fb_div_i  in  12  feedback divider, sampled when start_i is accepted.
- pll_locked_i  in  1  PLL lock status, already synchronised to clk_i.
- pll_ref_div_o  out  4  latched reference divider.
- pll_fb_div_o  out  12  latched feedback divider.
- pll_cfg_valid_o  out  1  one-cycle pulse that loads the PLL dividers.
- core_clk_en_o  out  1  domain clock-gate enable.
- core_rst_no  out  1  domain reset, active low.
- busy_o  out  1  sequence in progress.
- running_o  out  1  domain is up; state is RUN.
- err_o  out  1  state is ERROR.
- state_o  out  3  encoded current state, for status readback.

## Operation
- States: OFF, PLL_CFG, LOCK_WAIT, SETTLE, CLK_ON, RUN, STOP_RST, ERROR.
- **OFF**: clk_en=0, rst_n=0.
  - On start_i, latch the dividers.
  - If either divider is 0, go to ERROR. Otherwise go to PLL_CFG.
- **PLL_CFG**: lasts one cycle; pll_cfg_valid_o=1. Go to LOCK_WAIT and clear the counter.
- **LOCK_WAIT**:
  - pll_locked_i=1: go to SETTLE and clear the counter.
  - Otherwise increment the counter. When the counter reaches LOCK_TIMEOUT-1, go to ERROR (macro-dependent, see Configuration).
- **SETTLE**:
  - pll_locked_i=0: return to LOCK_WAIT and clear the counter.
  - After SETTLE_CYCLES consecutive locked cycles, go to CLK_ON.
- **CLK_ON**: clk_en=1, rst_n=0. After RST_HOLD_CYCLES, go to RUN.
- **RUN**: clk_en=1, rst_n=1.
  - stop_i: go to STOP_RST.
  - pll_locked_i=0: go to ERROR.
- **STOP_RST**: clk_en=1, rst_n=0. After RST_HOLD_CYCLES, go to OFF.
- **ERROR**: clk_en=0, rst_n=0, err_o=1. start_i is ignored; stop_i goes to OFF.
- Boundary rules:
  - stop_i in PLL_CFG, LOCK_WAIT or SETTLE goes straight to OFF; the clock was never enabled.
  - stop_i in CLK_ON goes to STOP_RST with the counter cleared.
  - If start_i and stop_i are high in the same cycle, stop wins. In OFF, the pair is a no-op.
  - start_i outside OFF is ignored. The latched dividers are held until the next accepted start.
  - Counter is 32-bit-free: width is $clog2 of the largest of the three parameters, and it saturates rather than wraps.
- Output flags:
  - busy_o = state in {PLL_CFG, LOCK_WAIT, SETTLE, CLK_ON, STOP_RST}.
  - running_o = state is RUN.

## Timing
- State, counter, core_clk_en_o, core_rst_no, pll_cfg_valid_o and the latched dividers are all flops, updated on the same rising edge. core_clk_en_o and core_rst_no never glitch.
- Reset values: state=OFF, core_clk_en_o=0, core_rst_no=0, pll_cfg_valid_o=0, dividers=0, busy_o=0, running_o=0, err_o=0, state_o=OFF.
- An asynchronous reset mid-sequence forces the reset values immediately: clock gated, domain held in reset.
- Power-up latency with lock already present, measured from the edge that samples start_i:
  - pll_cfg_valid_o high at cycle 1.
  - State is SETTLE from cycle 3.
  - core_clk_en_o rises at 3+SETTLE_CYCLES.
  - core_rst_no rises at 3+SETTLE_CYCLES+RST_HOLD_CYCLES; with defaults, cycle 27.
- Power-down latency: core_rst_no falls 1 cycle after stop_i is sampled in RUN; core_clk_en_o falls RST_HOLD_CYCLES later.

## Configuration
- CORE_PWR_SEQ_TIMEOUT_EN defined: the LOCK_WAIT timeout is active; LOCK_TIMEOUT-1 cycles without lock go to ERROR.
- Not defined: LOCK_WAIT waits indefinitely for lock. ERROR is reachable only through a zero divider or lock loss in RUN. LOCK_TIMEOUT is ignored, and the counter is sized from SETTLE_CYCLES and RST_HOLD_CYCLES only.

## Structure
- sys_ctrl_pkg gains:
  - pwr_seq_state_e, a 3-bit enum of the eight states; state_o is this enum cast to logic.
  - Default constants for LOCK_TIMEOUT, SETTLE_CYCLES and RST_HOLD_CYCLES.
- One sub-module, pwr_seq_timer: a loadable, clearable, saturating up-counter with a terminal-count compare, shared by SETTLE, CLK_ON, STOP_RST and LOCK_WAIT.

## Test plan
- pll_locked_i tied 1; start_i with ref=2, fb=100 -> pll_cfg_valid_o pulses at cycle 1 with 2/100; core_clk_en_o rises at cycle 19; core_rst_no rises at cycle 27; running_o=1.
- Lock drops for 1 cycle at SETTLE cycle 10 -> return to LOCK_WAIT; after relock, a full 16-cycle SETTLE before the clock is enabled.
- Macro defined, lock never asserted -> err_o=1 at LOCK_WAIT count 4095, core_clk_en_o=0; stop_i -> OFF, err_o=0.
- start_i with fb_div_i=0 -> ERROR on the next cycle, no pll_cfg_valid_o pulse; a following start_i is ignored.
- RUN, then stop_i -> core_rst_no=0 next cycle; core_clk_en_o=0 8 cycles later; state OFF. Lock loss in RUN -> ERROR with clock gated.
- rst_ni asserted in CLK_ON, and start_i+stop_i in the same cycle in LOCK_WAIT -> reset values immediately; OFF next cycle respectively.
